// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial unsigned adder, {Cout,Result} = A + B + Cin, one
//             full-adder stage and a registered carry, WIDTH bits per result.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 partial-sum bits need storing; the bit produced
  // on the final edge goes straight into Result.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             w_sum_bit;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_sum_next;

  assign w_sum_bit    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) |
                        (r_a_sh[0] & r_carry)   |
                        (r_b_sh[0] & r_carry);
  assign w_sum_next   = {w_sum_bit, r_sum_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      Result   <= '0;
      Cout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_carry  <= Cin;
            r_sum_sh <= '0;
            r_count  <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_SHIFT: begin
          r_carry  <= w_carry_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= w_sum_next[WIDTH-1:1];
          if (r_count == C_LAST) begin
            // Publish only the completed sum; count is cleared so it never wraps.
            Result  <= w_sum_next;
            Cout    <= w_carry_next;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + C_ONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Self-checking bench for serial_adder at WIDTH=4 and WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       cin4, cin8;
  logic [3:0] res4;
  logic [7:0] res8;
  logic       cout4, cout8, busy4, busy8, done4, done8;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_res [2];
  logic       prev_cout[2];

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .Result(res4), .Cout(cout4), .busy(busy4), .done(done4)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .Result(res8), .Cout(cout8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s);
    if (w == 8) begin
      a8 = a; b8 = b; cin8 = c; start8 = s;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = s;
    end
  endtask

  function automatic logic [7:0] get_res(input int w);
    return (w == 8) ? res8 : {4'b0, res4};
  endfunction
  function automatic logic get_cout(input int w);
    return (w == 8) ? cout8 : cout4;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  task automatic chk_outs(input int w, input string tag, input logic eb, input logic ed,
                          input logic [7:0] er, input logic ec);
    check({tag, ".busy"},   32'(get_busy(w)), 32'(eb));
    check({tag, ".done"},   32'(get_done(w)), 32'(ed));
    check({tag, ".result"}, 32'(get_res(w)),  32'(er));
    check({tag, ".cout"},   32'(get_cout(w)), 32'(ec));
  endtask

  // One operation: optional idle gap, start pulse, WIDTH busy cycles, done.
  // Reference model is plain integer addition of the captured operands.
  task automatic op(input int w, input logic [7:0] a_in, input logic [7:0] b_in,
                    input logic c, input int gap, input bit noise);
    int         k;
    logic [7:0] mask;
    logic [7:0] a, b;
    logic [8:0] sum;
    logic [31:0] rnd;
    k    = (w == 8) ? 1 : 0;
    mask = (w == 8) ? 8'hFF : 8'h0F;
    a    = a_in & mask;
    b    = b_in & mask;
    sum  = {1'b0, a} + {1'b0, b} + {8'b0, c};
    for (int g = 0; g < gap; g++) begin
      set_in(w, 8'h0, 8'h0, 1'b0, 1'b0);
      tick();
      chk_outs(w, "idle", 1'b0, 1'b0, prev_res[k], prev_cout[k]);
    end
    set_in(w, a, b, c, 1'b1);
    tick();
    for (int i = 0; i < w; i++) begin
      chk_outs(w, "shift", 1'b1, 1'b0, prev_res[k], prev_cout[k]);
      if (noise) begin
        rnd = $urandom;
        set_in(w, rnd[7:0], rnd[15:8], rnd[16], rnd[17]);
      end else begin
        set_in(w, a, b, c, 1'b0);
      end
      tick();
    end
    prev_res[k]  = sum[7:0] & mask;
    prev_cout[k] = sum[w];
    chk_outs(w, "done", 1'b0, 1'b1, prev_res[k], prev_cout[k]);
    set_in(w, 8'h0, 8'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    set_in(4, 8'h0, 8'h0, 1'b0, 1'b0);
    set_in(8, 8'h0, 8'h0, 1'b0, 1'b0);
    prev_res[0] = 8'h0; prev_res[1] = 8'h0;
    prev_cout[0] = 1'b0; prev_cout[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_outs(4, "reset4", 1'b0, 1'b0, 8'h0, 1'b0);
    chk_outs(8, "reset8", 1'b0, 1'b0, 8'h0, 1'b0);

    // Directed cases on the WIDTH=4 instance
    op(4, 8'd5,  8'd3, 1'b0, 1, 1'b0);
    op(4, 8'd15, 8'd1, 1'b0, 1, 1'b0);
    op(4, 8'd9,  8'd6, 1'b1, 2, 1'b0);
    op(4, 8'd0,  8'd0, 1'b1, 1, 1'b0);
    op(4, 8'd2,  8'd2, 1'b0, 1, 1'b1);
    op(4, 8'd7,  8'd7, 1'b0, 1, 1'b0);
    op(4, 8'd8,  8'd8, 1'b0, 0, 1'b0);

    // Reset during the second shift cycle aborts and clears outputs
    set_in(4, 8'd10, 8'd3, 1'b0, 1'b1);
    tick();
    check("abort.busy_start", 32'(busy4), 32'd1);
    set_in(4, 8'd10, 8'd3, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_res[0] = 8'h0; prev_cout[0] = 1'b0;
    prev_res[1] = 8'h0; prev_cout[1] = 1'b0;
    chk_outs(4, "abort", 1'b0, 1'b0, 8'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_outs(4, "abort_quiet", 1'b0, 1'b0, 8'h0, 1'b0);
    end
    op(4, 8'd10, 8'd3, 1'b0, 1, 1'b0);

    // Randomized operations, both widths, random gaps and input noise
    for (int n = 0; n < 1000; n++) begin
      r = $urandom;
      op(4, r[7:0], r[15:8], r[16], int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 1000; n++) begin
      r = $urandom;
      op(8, r[7:0], r[15:8], r[16], int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end
    tick();
    chk_outs(8, "final8", 1'b0, 1'b0, prev_res[1], prev_cout[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
